gates_unit: RTL and testbench
=============================

Name: gates_unit

Overview:
- Registered bitwise logic unit that computes AND, OR and NOT of two operand vectors, with one cycle of latency and a valid qualifier.
- Sits as a small datapath leaf; it is used as a logic primitive and as a bring-up/demo block for the simulation flow.
- Also keeps a saturating count of accepted input vectors for debug visibility.

Parameters:
- WIDTH, 1, bit width of operands A, B and of every logic result output.
- CNT_W, 16, width of the accepted-vector counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies A/B in the current cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- AND  output  WIDTH  registered A & B.
- OR  output  WIDTH  registered A | B.
- NOT  output  WIDTH  registered ~A (B ignored).
- NAND  output  WIDTH  registered ~(A & B); present only with the optional feature.
- NOR  output  WIDTH  registered ~(A | B); present only with the optional feature.
- XOR  output  WIDTH  registered A ^ B; present only with the optional feature.
- XNOR  output  WIDTH  registered ~(A ^ B); present only with the optional feature.
- out_valid  output  1  result registers updated on the previous edge.
- vec_count  output  CNT_W  number of accepted vectors, saturating.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - all result outputs are 0, including NOT;
  - out_valid=0;
  - vec_count=0.
- Reset released mid-stream: no pending result survives; the first result appears one cycle after the first in_valid sampled with rst=0.
- Accept: on a clk rising edge with in_valid=1, every result register loads its bitwise function of the sampled A/B, and out_valid=1 the next cycle.
- Latency: exactly 1 cycle, input sample edge to output.
- Throughput: one vector per cycle; back-to-back in_valid gives back-to-back out_valid with no bubbles.
- Idle: on an edge with in_valid=0, result registers hold their previous values and out_valid goes 0.
- All operations are per-bit and independent; there is no carry or cross-bit interaction.
- NOT depends only on A.
- vec_count:
  - increments by 1 on each accepted vector;
  - holds at 2^CNT_W-1 (all ones) and never wraps.
- Outputs are glitch-free: driven only from flops, with no combinational path from inputs to outputs.
- X on A/B while in_valid=0 must not propagate into the result registers.

Optional Feature:
- Macro: GATES_EXT_OPS_EN.
- Defined: NAND, NOR, XOR and XNOR ports exist. They are registered identically to AND/OR: same latency, same hold on idle, reset to 0.
- Not defined: those four ports and their registers are omitted. AND/OR/NOT, out_valid and vec_count behave identically either way.

Test Plan:
- Truth table at WIDTH=1. Apply in_valid=1 with (A,B) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles. One cycle after each, require:
  - AND = 0,0,0,1;
  - OR = 0,1,1,1;
  - NOT = 1,1,0,0;
  - out_valid=1 each cycle;
  - vec_count = 1,2,3,4.
- Reset values: assert rst asynchronously between clock edges after loading A=1, B=1. Require immediately AND=0, OR=0, NOT=0, out_valid=0, vec_count=0, without waiting for a clk edge.
- Hold on idle: load A=1, B=0, then hold in_valid=0 for 3 cycles while A/B toggle. Require:
  - AND=0, OR=1, NOT=0 held throughout;
  - out_valid=0 after the first idle cycle;
  - vec_count unchanged.
- Vector width: WIDTH=8, A=8'hF0, B=8'h3C. Require:
  - AND=8'h30, OR=8'hFC, NOT=8'h0F;
  - with GATES_EXT_OPS_EN: NAND=8'hCF, NOR=8'h03, XOR=8'hCC, XNOR=8'h33.
- Counter saturation: CNT_W=4, 20 consecutive valid vectors. Require vec_count to reach 15 and stay at 15.
- Mid-stream reset: 3 accepted vectors, then rst pulse, then 1 vector. Require vec_count=1 and out_valid asserted exactly one cycle after that vector.

Source files
------------

// File: rtl/gates_unit_if.sv
// Operand/result bundle for gates_unit. The NAND/NOR/XOR/XNOR signals exist
// only when GATES_EXT_OPS_EN is defined.
interface gates_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] AND;
  logic [WIDTH-1:0] OR;
  logic [WIDTH-1:0] NOT;
`ifdef GATES_EXT_OPS_EN
  logic [WIDTH-1:0] NAND;
  logic [WIDTH-1:0] NOR;
  logic [WIDTH-1:0] XOR;
  logic [WIDTH-1:0] XNOR;
`endif
  logic             out_valid;
  logic [CNT_W-1:0] vec_count;

  modport master (
    output in_valid, A, B,
    input  AND, OR, NOT,
`ifdef GATES_EXT_OPS_EN
    input  NAND, NOR, XOR, XNOR,
`endif
    input  out_valid, vec_count
  );

  modport slave (
    input  in_valid, A, B,
    output AND, OR, NOT,
`ifdef GATES_EXT_OPS_EN
    output NAND, NOR, XOR, XNOR,
`endif
    output out_valid, vec_count
  );
endinterface

// File: rtl/gates_unit.sv
// Registered bitwise logic unit (1-cycle latency) with a saturating count of
// accepted vectors. GATES_EXT_OPS_EN adds NAND/NOR/XOR/XNOR results.
module gates_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  gates_unit_if.slave bus
);
  logic [WIDTH-1:0] and_q, or_q, not_q;
`ifdef GATES_EXT_OPS_EN
  logic [WIDTH-1:0] nand_q, nor_q, xor_q, xnor_q;
`endif
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Result registers load only on accept, so idle-cycle X on A/B never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and_q  <= '0;
      or_q   <= '0;
      not_q  <= '0;
`ifdef GATES_EXT_OPS_EN
      nand_q <= '0;
      nor_q  <= '0;
      xor_q  <= '0;
      xnor_q <= '0;
`endif
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q <= bus.in_valid;
      cnt_q <= cnt_d;
      if (bus.in_valid) begin
        and_q  <= bus.A & bus.B;
        or_q   <= bus.A | bus.B;
        not_q  <= ~bus.A;
`ifdef GATES_EXT_OPS_EN
        nand_q <= ~(bus.A & bus.B);
        nor_q  <= ~(bus.A | bus.B);
        xor_q  <= bus.A ^ bus.B;
        xnor_q <= ~(bus.A ^ bus.B);
`endif
      end
    end
  end

  assign bus.AND       = and_q;
  assign bus.OR        = or_q;
  assign bus.NOT       = not_q;
`ifdef GATES_EXT_OPS_EN
  assign bus.NAND      = nand_q;
  assign bus.NOR       = nor_q;
  assign bus.XOR       = xor_q;
  assign bus.XNOR      = xnor_q;
`endif
  assign bus.out_valid = vld_q;
  assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_gates_unit.sv
// Directed bench: a WIDTH=1/CNT_W=16 instance and a WIDTH=8/CNT_W=4 instance
// share clock and reset.
module tb_gates_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gates_unit_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  gates_unit_if #(.WIDTH(8), .CNT_W(4))  if8 ();

  gates_unit #(.WIDTH(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  gates_unit #(.WIDTH(8), .CNT_W(4))  u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Async pulse placed between edges; checks values while rst is still high.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    chk("rst_and1",  if1.AND, 0);
    chk("rst_or1",   if1.OR, 0);
    chk("rst_not1",  if1.NOT, 0);
    chk("rst_vld1",  if1.out_valid, 0);
    chk("rst_cnt1",  if1.vec_count, 0);
    chk("rst_vld8",  if8.out_valid, 0);
    chk("rst_cnt8",  if8.vec_count, 0);
    #1 rst = 1'b0;
  endtask

  logic [1:0] ab1;
  logic [3:0] exp_and, exp_or, exp_not;

  initial begin
    if1.in_valid = 1'b0; if1.A = '0; if1.B = '0;
    if8.in_valid = 1'b0; if8.A = '0; if8.B = '0;
    #2;
    chk("init_and", if1.AND, 0);
    chk("init_not", if1.NOT, 0);
    chk("init_vld", if1.out_valid, 0);
    chk("init_cnt", if1.vec_count, 0);
    step();
    rst = 1'b0;

    // Truth table, back-to-back
    exp_and = 4'b1000; exp_or = 4'b1110; exp_not = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      ab1 = i[1:0];
      if1.in_valid = 1'b1; if1.A = ab1[1]; if1.B = ab1[0];
      step();
      chk($sformatf("tt_and%0d", i), if1.AND, exp_and[i]);
      chk($sformatf("tt_or%0d", i),  if1.OR,  exp_or[i]);
      chk($sformatf("tt_not%0d", i), if1.NOT, exp_not[i]);
      chk($sformatf("tt_vld%0d", i), if1.out_valid, 1);
      chk($sformatf("tt_cnt%0d", i), if1.vec_count, i + 1);
    end

    // Load A=1,B=1 then reset asynchronously mid-cycle
    if1.A = 1'b1; if1.B = 1'b1;
    step();
    chk("pre_rst_and", if1.AND, 1);
    if1.in_valid = 1'b0;
    pulse_rst();

    // Hold on idle
    if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b0;
    step();
    chk("hold_and0", if1.AND, 0);
    chk("hold_or0",  if1.OR, 1);
    chk("hold_vld0", if1.out_valid, 1);
    if1.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if1.A = ~if1.A; if1.B = ~if1.B;
      step();
      chk($sformatf("hold_and%0d", i + 1), if1.AND, 0);
      chk($sformatf("hold_or%0d", i + 1),  if1.OR, 1);
      chk($sformatf("hold_not%0d", i + 1), if1.NOT, 0);
      chk($sformatf("hold_vld%0d", i + 1), if1.out_valid, 0);
      chk($sformatf("hold_cnt%0d", i + 1), if1.vec_count, 1);
    end

    // 8-bit vector
    if8.in_valid = 1'b1; if8.A = 8'hF0; if8.B = 8'h3C;
    step();
    if8.in_valid = 1'b0;
    chk("w8_and", if8.AND, 8'h30);
    chk("w8_or",  if8.OR,  8'hFC);
    chk("w8_not", if8.NOT, 8'h0F);
    chk("w8_vld", if8.out_valid, 1);
`ifdef GATES_EXT_OPS_EN
    chk("w8_nand", if8.NAND, 8'hCF);
    chk("w8_nor",  if8.NOR,  8'h03);
    chk("w8_xor",  if8.XOR,  8'hCC);
    chk("w8_xnor", if8.XNOR, 8'h33);
`endif
    if8.A = 8'hAA; if8.B = 8'h55;
    step();
    chk("w8_hold_and", if8.AND, 8'h30);
    chk("w8_hold_vld", if8.out_valid, 0);

    // Saturation at CNT_W=4
    pulse_rst();
    if8.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if8.A = 8'(i); if8.B = 8'(i * 3);
      step();
      chk($sformatf("sat%0d", i), if8.vec_count, (i + 1 > 15) ? 15 : i + 1);
    end
    if8.in_valid = 1'b0;

    // Mid-stream reset
    pulse_rst();
    if1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if1.A = 1'(i); if1.B = 1'b1;
      step();
    end
    chk("ms_cnt_pre", if1.vec_count, 3);
    if1.in_valid = 1'b0;
    pulse_rst();
    step();
    chk("ms_vld_idle", if1.out_valid, 0);
    if1.in_valid = 1'b1; if1.A = 1'b0; if1.B = 1'b1;
    step();
    if1.in_valid = 1'b0;
    chk("ms_vld", if1.out_valid, 1);
    chk("ms_cnt", if1.vec_count, 1);
    chk("ms_or",  if1.OR, 1);
    step();
    chk("ms_vld_after", if1.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
